jstk_reader: RTL

Serial game-pad scanner for the picorv32 SoC. Periodically drives the latch/clock lines of a 16-bit shift-register pad (SNES-style), samples the serial data line and presents the decoded, active-high button state on `jstk_state[15:0]`. That output feeds the system-control register block, which returns it to the CPU on reads.

---
 rtl/jstk_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/jstk_reader.sv
// Serial game-pad scanner: drives latch/clock of a 16-bit shift-register pad and
// publishes active-high button state. Optional build macro: JSTK_DEBOUNCE_EN.
module jstk_reader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SCAN_GAP = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        scan_en,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] jstk_state,
    output logic        scan_done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSample,
        StClkLo,
        StDone
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_idx;
    logic [15:0]      shift;
    logic [1:0]       data_sync;
    logic             data_s;
    logic             tick;

`ifdef JSTK_DEBOUNCE_EN
    logic [15:0]      prev_shift;
`endif

    // Free-running tick divider; one tick is one pad half-period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // pad_data is asynchronous; idle line level is high (no button pressed).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sync <= 2'b11;
        end else begin
            data_sync <= {data_sync[0], pad_data};
        end
    end

    assign data_s = data_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            gap_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= 16'hFFFF;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b1;
            jstk_state <= 16'h0000;
            scan_done  <= 1'b0;
`ifdef JSTK_DEBOUNCE_EN
            prev_shift <= 16'hFFFF;
`endif
        end else begin
            scan_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tick) begin
                        // Saturate at the last gap tick until scanning is enabled.
                        if (gap_cnt == GAP_LAST) begin
                            if (scan_en) begin
                                state     <= StLatch;
                                pad_latch <= 1'b1;
                                gap_cnt   <= '0;
                                bit_idx   <= '0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end

                StLatch: begin
                    // bit_idx doubles as the latch-phase tick counter.
                    if (tick) begin
                        if (bit_idx == 4'd1) begin
                            state     <= StSample;
                            pad_latch <= 1'b0;
                            bit_idx   <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end

                StSample: begin
                    if (tick) begin
                        shift[bit_idx] <= data_s;
                        pad_clk        <= 1'b0;
                        state          <= StClkLo;
                    end
                end

                StClkLo: begin
                    if (tick) begin
                        pad_clk <= 1'b1;
                        if (bit_idx == 4'd15) begin
                            state <= StDone;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            state   <= StSample;
                        end
                    end
                end

                StDone: begin
                    scan_done <= 1'b1;
                    bit_idx   <= '0;
                    state     <= StIdle;
`ifdef JSTK_DEBOUNCE_EN
                    // Publish only once two consecutive scans agree.
                    if (shift == prev_shift) begin
                        jstk_state <= ~shift;
                    end
                    prev_shift <= shift;
`else
                    jstk_state <= ~shift;
`endif
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
